tmds_lane_gearbox: RTL and testbench

Parametrised single-clock parallel-to-serial gearbox for the video output path. It accepts one word per channel through a valid/ready interface into a small FIFO. Each word is emitted as BITS_PER_CYCLE-wide slices on `clk_pixel_x5`, with selectable bit order, idle-word insertion on underflow, and a generated clock lane. Its slice outputs feed per-pin SDR flops (BITS_PER_CYCLE=1) or DDR output primitives (BITS_PER_CYCLE=2) in the vendor I/O wrapper.

---
 rtl/tmds_lane_gearbox.sv | 121 ++++++++++++
 tb/tb_tmds_lane_gearbox.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_lane_gearbox.sv
// Parallel-to-serial gearbox for the TMDS output path: a small input FIFO feeds
// per-lane shift registers that emit BITS_PER_CYCLE-wide slices plus a clock lane.
module tmds_lane_gearbox #(
  parameter int unsigned             NUM_CHANNELS   = 3,
  parameter int unsigned             WORD_WIDTH     = 10,
  parameter int unsigned             BITS_PER_CYCLE = 2,
  parameter bit                      MSB_FIRST      = 1'b0,
  parameter int unsigned             FIFO_DEPTH     = 4,
  parameter logic [WORD_WIDTH-1:0]   IDLE_WORD      = 10'b1101010100,
  parameter logic [WORD_WIDTH-1:0]   CLOCK_PATTERN  = 10'b0000011111
) (
  input  logic                                   clk_pixel_x5,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0]     in_data,
  input  logic                                   enable,
  input  logic                                   underflow_clear,
  output logic [NUM_CHANNELS*BITS_PER_CYCLE-1:0] ser_out,
  output logic [BITS_PER_CYCLE-1:0]              ser_clock,
  output logic                                   word_start,
  output logic                                   underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level
);

  localparam int unsigned SLICES = WORD_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned DATA_W = NUM_CHANNELS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

  logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [CNT_W-1:0]      slice_cnt;
  logic [WORD_WIDTH-1:0] lane_sr   [NUM_CHANNELS];
  logic [WORD_WIDTH-1:0] load_word [NUM_CHANNELS];
  logic [WORD_WIDTH-1:0] clk_sr;

  // MSB-first order is realised by bit-reversing at load, so the shifters
  // always emit from the low end.
  function automatic logic [WORD_WIDTH-1:0] order_bits(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = w;
    if (MSB_FIRST) begin
      for (int unsigned n = 0; n < WORD_WIDTH; n++) r[n] = w[WORD_WIDTH-1-n];
    end
    return r;
  endfunction

  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign load       = (slice_cnt == LAST_SLICE);
  assign pop        = load && enable && !empty;
  assign fifo_level = level;

  always_ff @(posedge clk_pixel_x5) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (!push && pop) level <= level - LVL_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      load_word[i] = order_bits(pop ? fifo_mem[rd_ptr][i*WORD_WIDTH +: WORD_WIDTH] : IDLE_WORD);
    end
  end

  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      slice_cnt  <= LAST_SLICE;
      clk_sr     <= '0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) lane_sr[i] <= '0;
    end else begin
      word_start <= load;
      if (load) begin
        slice_cnt <= '0;
        clk_sr    <= order_bits(CLOCK_PATTERN);
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) lane_sr[i] <= load_word[i];
      end else begin
        slice_cnt <= slice_cnt + CNT_W'(1);
        clk_sr    <= clk_sr >> BITS_PER_CYCLE;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) lane_sr[i] <= lane_sr[i] >> BITS_PER_CYCLE;
      end
      // A new underflow on this edge takes priority over a clear request.
      if (load && enable && empty) underflow <= 1'b1;
      else if (underflow_clear)    underflow <= 1'b0;
    end
  end

  always_comb begin
    ser_out = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      ser_out[i*BITS_PER_CYCLE +: BITS_PER_CYCLE] = lane_sr[i][BITS_PER_CYCLE-1:0];
    end
    ser_clock = clk_sr[BITS_PER_CYCLE-1:0];
  end

endmodule

// File: tb/tb_tmds_lane_gearbox.sv
// Directed bench for tmds_lane_gearbox: default, MSB-first and 1-bit-slice
// instances share one stimulus stream.
module tb_tmds_lane_gearbox;

  logic        clk_pixel_x5 = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [29:0] in_data;
  logic        enable;
  logic        underflow_clear;

  logic        in_ready, word_start, underflow;
  logic [5:0]  ser_out;
  logic [1:0]  ser_clock;
  logic [2:0]  fifo_level;

  logic        m_in_ready, m_word_start, m_underflow;
  logic [5:0]  m_ser_out;
  logic [1:0]  m_ser_clock;
  logic [2:0]  m_fifo_level;

  logic        b_in_ready, b_word_start, b_underflow;
  logic [2:0]  b_ser_out;
  logic [0:0]  b_ser_clock;
  logic [2:0]  b_fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk_pixel_x5 = ~clk_pixel_x5;

  tmds_lane_gearbox dut (
    .clk_pixel_x5(clk_pixel_x5), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .enable(enable), .underflow_clear(underflow_clear), .ser_out(ser_out),
    .ser_clock(ser_clock), .word_start(word_start), .underflow(underflow), .fifo_level(fifo_level)
  );

  tmds_lane_gearbox #(.MSB_FIRST(1'b1)) dut_msb (
    .clk_pixel_x5(clk_pixel_x5), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .enable(enable), .underflow_clear(underflow_clear), .ser_out(m_ser_out),
    .ser_clock(m_ser_clock), .word_start(m_word_start), .underflow(m_underflow), .fifo_level(m_fifo_level)
  );

  tmds_lane_gearbox #(.BITS_PER_CYCLE(1)) dut_b1 (
    .clk_pixel_x5(clk_pixel_x5), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .enable(enable), .underflow_clear(underflow_clear), .ser_out(b_ser_out),
    .ser_clock(b_ser_clock), .word_start(b_word_start), .underflow(b_underflow), .fifo_level(b_fifo_level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a word offered while in_ready was high is withdrawn once taken.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk_pixel_x5);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [29:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic wait_ws(input int bound);
    int n = 0;
    do begin tick(); n++; end while (!word_start && n < bound);
    check("ws_wait", word_start, 1'b1);
  endtask

  task automatic wait_ws_b1(input int bound);
    int n = 0;
    do begin tick(); n++; end while (!b_word_start && n < bound);
    check("b1_ws_wait", b_word_start, 1'b1);
  endtask

  task automatic capture(output logic [29:0] w);
    w = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check("ws_slice", word_start, k == 0);
      for (int i = 0; i < 3; i++) w[i*10 + k*2 +: 2] = ser_out[i*2 +: 2];
    end
  endtask

  task automatic capture_b1(output logic [29:0] w);
    w = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check("b1_ws_slice", b_word_start, k == 0);
      check("b1_clock", b_ser_clock, k < 5);
      for (int i = 0; i < 3; i++) w[i*10 + k] = b_ser_out[i];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  idle_sl [5];
    logic [1:0]  clk_sl  [5];
    logic [1:0]  lsb_sl  [5];
    logic [1:0]  msb_sl  [5];
    logic [29:0] dq [5];
    logic [29:0] w;
    logic [29:0] d6;

    idle_sl = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    clk_sl  = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd0};
    lsb_sl  = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    msb_sl  = '{2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    dq[0] = {10'h001, 10'h3FE, 10'h155};
    dq[1] = {10'h0F0, 10'h30F, 10'h2AA};
    dq[2] = {10'h123, 10'h0C7, 10'h3C3};
    dq[3] = {10'h200, 10'h001, 10'h18C};
    dq[4] = {10'h3FF, 10'h000, 10'h2D4};
    d6    = {10'h2B7, 10'h04D, 10'h391};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b1; underflow_clear = 1'b0;
    repeat (3) @(posedge clk_pixel_x5);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ser_out", ser_out, 6'd0);
    check("rst_ser_clock", ser_clock, 2'd0);
    check("rst_word_start", word_start, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    reset = 1'b0;

    // Idle stream with enable high and nothing queued.
    for (int k = 0; k < 9; k++) begin
      tick();
      check("idle_ws", word_start, (k % 5) == 0);
      check("idle_ser_out", ser_out, {3{idle_sl[k % 5]}});
      check("idle_clock", ser_clock, clk_sl[k % 5]);
      if (k == 0) check("idle_underflow", underflow, 1'b1);
    end

    // Push aligned so the next edge is a load point.
    in_data = {10'h0F0, 10'h155, 10'h3A5}; in_valid = 1'b1; underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    check("push_level", fifo_level, 3'd1);
    check("uf_cleared", underflow, 1'b0);
    in_data = {10'h1E1, 10'h0AA, 10'h2C3}; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("w1_ws", word_start, k == 0);
      check("w1_lane0", ser_out[1:0], lsb_sl[k]);
      check("w1_msb_lane0", m_ser_out[1:0], msb_sl[k]);
      if (k == 0) check("w1_level", fifo_level, 3'd1);
    end
    wait_ws(10);
    capture(w);
    check("w2_word", w, {10'h1E1, 10'h0AA, 10'h2C3});
    check("w2_underflow", underflow, 1'b0);
    check("w2_level", fifo_level, 3'd0);

    // Fill the FIFO with enable low, then drain in order.
    enable = 1'b0;
    for (int n = 0; n < 4; n++) push_word(dq[n]);
    check("full_level", fifo_level, 3'd4);
    check("full_ready", in_ready, 1'b0);
    in_data = dq[4]; in_valid = 1'b1;
    tick();
    check("full_hold_level", fifo_level, 3'd4);
    check("full_hold_ready", in_ready, 1'b0);
    check("dis_underflow", underflow, 1'b0);
    enable = 1'b1;
    wait_ws(10);
    check("pop1_level", fifo_level, 3'd3);
    check("pop1_ready", in_ready, 1'b1);
    capture(w);
    check("d1_word", w, dq[0]);
    check("d5_accepted_level", fifo_level, 3'd4);
    for (int n = 1; n < 5; n++) begin
      wait_ws(10);
      capture(w);
      check("dn_word", w, dq[n]);
    end
    check("drain_level", fifo_level, 3'd0);
    check("drain_underflow", underflow, 1'b0);

    // Reset mid-word with three words queued.
    enable = 1'b0;
    push_word({10'h011, 10'h022, 10'h033});
    push_word({10'h044, 10'h055, 10'h066});
    push_word({10'h077, 10'h088, 10'h099});
    check("pre_rst_level", fifo_level, 3'd3);
    check("pre_rst_ser_out", ser_out, {3{idle_sl[2]}});
    reset = 1'b1;
    #1;
    check("arst_ser_out", ser_out, 6'd0);
    check("arst_ser_clock", ser_clock, 2'd0);
    check("arst_level", fifo_level, 3'd0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_ws", word_start, 1'b0);
    repeat (2) @(posedge clk_pixel_x5);
    #1;
    enable = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_ws", word_start, k == 0);
      check("post_rst_ser_out", ser_out, {3{idle_sl[k]}});
      check("post_rst_clock", ser_clock, clk_sl[k]);
      check("post_rst_level", fifo_level, 3'd0);
    end
    check("post_rst_underflow", underflow, 1'b1);

    // Clear held across a load edge that underflows again: the set wins there.
    underflow_clear = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("uf_set_wins", underflow, (k == 0) || (k == 5));
    end
    underflow_clear = 1'b0;

    // One-bit slices: ten-cycle words.
    reset = 1'b1;
    #1;
    check("b1_rst_ser_out", b_ser_out, 3'd0);
    check("b1_rst_ws", b_word_start, 1'b0);
    @(posedge clk_pixel_x5);
    #1;
    reset = 1'b0;
    push_word(d6);
    wait_ws_b1(20);
    capture_b1(w);
    check("b1_word", w, d6);
    tick();
    check("b1_ws_period", b_word_start, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
